// File: rtl/axi_rt_frag_pkg.sv
// Shared types and helpers for the runtime-limited AXI address-channel fragmenter.
package axi_rt_frag_pkg;

  typedef enum logic {Idle, Split} state_e;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  // Default channel layout; real instances override chan_t with their AW/AR struct.
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_chan_t;

  function automatic logic [8:0] frag_beats(input logic [8:0] rem, input logic [7:0] lim);
    logic [8:0] cap;
    cap = {1'b0, lim} + 9'd1;
    return (rem < cap) ? rem : cap;
  endfunction

  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [8:0] beats);
    logic [63:0] mask;
    mask = ~((64'd1 << size) - 64'd1);
    if (burst == BurstIncr) return (addr & mask) + (64'(beats) << size);
    return addr;
  endfunction

endpackage

// File: rtl/axi_rt_frag_fifo.sv
// 1-bit flag FIFO; full/empty come from a registered occupancy count.
module axi_rt_frag_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  logic wdata,
  input  logic pop,
  output logic rdata,
  output logic full,
  output logic empty
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/axi_rt_ax_fragmenter.sv
// Splits one INCR/FIXED burst into fragments of at most len_limit_i+1 beats,
// queueing a final-fragment flag per fragment for the response path.
module axi_rt_ax_fragmenter
  import axi_rt_frag_pkg::*;
#(
  parameter type         chan_t    = ax_chan_t,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned MaxTxns   = 4,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          len_limit_i,
  input  chan_t               ax_i,
  input  logic                ax_valid_i,
  output logic                ax_ready_o,
  output chan_t               ax_o,
  output logic                ax_valid_o,
  input  logic                ax_ready_i,
  output logic                frag_last_o,
  output logic                frag_valid_o,
  input  logic                frag_ready_i,
  input  logic                cnt_clr_i,
  output logic [CntWidth-1:0] frag_cnt_o,
  output logic                busy_o
);
  state_e               state_q, state_d;
  chan_t                ax_q;
  logic [AddrWidth-1:0] addr_q;
  logic [8:0]           rem_q, beats;
  logic [7:0]           lim_q;
  logic                 fifo_full, fifo_empty, last_frag, in_hs, out_hs;

  assign beats     = frag_beats(rem_q, lim_q);
  assign last_frag = (rem_q == beats);
  assign in_hs     = ax_valid_i & ax_ready_o;
  assign out_hs    = ax_valid_o & ax_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= Idle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ax_ready_o = 1'b0;
    ax_valid_o = 1'b0;
    ax_o       = ax_q;
    ax_o.addr  = addr_q;
    ax_o.len   = 8'(beats - 9'd1);
    case (state_q)
      Idle: begin
        ax_ready_o = 1'b1;
        if (ax_valid_i) state_d = Split;
      end
      Split: begin
        // Never issue a fragment without a slot for its flag.
        ax_valid_o = ~fifo_full;
        if (ax_valid_o && ax_ready_i && last_frag) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (in_hs) begin
      ax_q   <= ax_i;
      addr_q <= ax_i.addr;
      rem_q  <= {1'b0, ax_i.len} + 9'd1;
      // WRAP bursts pass through whole: an all-ones limit yields a single fragment.
      lim_q  <= (ax_i.burst == BurstWrap) ? 8'hFF : len_limit_i;
    end else if (out_hs) begin
      rem_q  <= rem_q - beats;
      addr_q <= AddrWidth'(next_addr(64'(addr_q), ax_q.size, ax_q.burst, beats));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i)            frag_cnt_o <= '0;
    else if (out_hs && ~&frag_cnt_o)   frag_cnt_o <= frag_cnt_o + 1'b1;
  end

  axi_rt_frag_fifo #(.Depth(MaxTxns)) u_flag_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (out_hs),
    .wdata (last_frag),
    .pop   (frag_ready_i),
    .rdata (frag_last_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign frag_valid_o = ~fifo_empty;
  assign busy_o       = (state_q == Split) | frag_valid_o;

endmodule

// File: tb/tb_axi_rt_ax_fragmenter.sv
// Directed bench for axi_rt_ax_fragmenter (flag FIFO depth 2).
module tb_axi_rt_ax_fragmenter;
  import axi_rt_frag_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  len_limit_i = 8'd0;
  ax_chan_t    ax_i = '0;
  logic        ax_valid_i = 1'b0;
  logic        ax_ready_o;
  ax_chan_t    ax_o;
  logic        ax_valid_o;
  logic        ax_ready_i = 1'b1;
  logic        frag_last_o, frag_valid_o;
  logic        frag_ready_i = 1'b1;
  logic        cnt_clr_i = 1'b0;
  logic [31:0] frag_cnt_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  int          n_frag, n_flag;
  logic [7:0]  f_len  [16];
  logic [31:0] f_addr [16];
  logic        f_flag [16];

  always #5 clk = ~clk;

  axi_rt_ax_fragmenter #(.chan_t(ax_chan_t), .AddrWidth(32), .MaxTxns(2), .CntWidth(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .len_limit_i(len_limit_i),
    .ax_i(ax_i), .ax_valid_i(ax_valid_i), .ax_ready_o(ax_ready_o),
    .ax_o(ax_o), .ax_valid_o(ax_valid_o), .ax_ready_i(ax_ready_i),
    .frag_last_o(frag_last_o), .frag_valid_o(frag_valid_o), .frag_ready_i(frag_ready_i),
    .cnt_clr_i(cnt_clr_i), .frag_cnt_o(frag_cnt_o), .busy_o(busy_o)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic ax_chan_t mk(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
    ax_chan_t a;
    a = '{id: 4'h5, addr: addr, len: len, size: size, burst: burst};
    return a;
  endfunction

  task automatic send(input ax_chan_t a);
    ax_i = a; ax_valid_i = 1'b1;
    tick();
    ax_valid_i = 1'b0; #1;
  endtask

  task automatic clr_cnt();
    cnt_clr_i = 1'b1; tick(); cnt_clr_i = 1'b0; #1;
  endtask

  task automatic collect(input int cycles);
    n_frag = 0; n_flag = 0;
    for (int c = 0; c < cycles; c++) begin
      if (ax_valid_o && ax_ready_i && n_frag < 16) begin
        f_len[n_frag] = ax_o.len; f_addr[n_frag] = ax_o.addr; n_frag++;
      end
      if (frag_valid_o && frag_ready_i && n_flag < 16) begin
        f_flag[n_flag] = frag_last_o; n_flag++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0; #1;
    checks++;
    if ({ax_ready_o, ax_valid_o, frag_valid_o, busy_o} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got %b want 1000", {ax_ready_o, ax_valid_o, frag_valid_o, busy_o});
    end
    checks++;
    if (frag_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", frag_cnt_o); end
  endtask

  task automatic test_incr_split();
    logic [31:0] ea [4];
    logic        ef [4];
    ea = '{32'h1002, 32'h1008, 32'h1010, 32'h1018};
    ef = '{1'b0, 1'b0, 1'b0, 1'b1};
    clr_cnt();
    len_limit_i = 8'd1;
    send(mk(32'h1002, 8'd7, 3'd2, BurstIncr));
    collect(10);
    checks++;
    if (n_frag !== 4 || n_flag !== 4) begin
      errors++; $display("FAIL incr_count frags %0d flags %0d want 4 4", n_frag, n_flag);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (f_len[i] !== 8'd1 || f_addr[i] !== ea[i] || f_flag[i] !== ef[i]) begin
          errors++;
          $display("FAIL incr_frag%0d got len %0d addr %h flag %b want len 1 addr %h flag %b",
                   i, f_len[i], f_addr[i], f_flag[i], ea[i], ef[i]);
        end
      end
    end
    checks++;
    if (frag_cnt_o !== 32'd4) begin errors++; $display("FAIL incr_cnt got %0d want 4", frag_cnt_o); end
  endtask

  task automatic test_back_to_back();
    ax_chan_t a, b;
    a = mk(32'h2000, 8'd3, 3'd3, BurstIncr);
    b = mk(32'h3000, 8'd3, 3'd3, BurstIncr);
    clr_cnt();
    len_limit_i = 8'hFF;
    ax_i = a; ax_valid_i = 1'b1;
    tick();
    ax_i = b; #1;
    checks++;
    if (ax_valid_o !== 1'b1 || ax_ready_o !== 1'b0 || ax_o !== a) begin
      errors++; $display("FAIL b2b_first got v %b r %b ax %h want v 1 r 0 ax %h", ax_valid_o, ax_ready_o, ax_o, a);
    end
    tick();
    checks++;
    if (ax_valid_o !== 1'b0 || ax_ready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_bubble got v %b r %b want v 0 r 1", ax_valid_o, ax_ready_o);
    end
    checks++;
    if (frag_valid_o !== 1'b1 || frag_last_o !== 1'b1 || frag_cnt_o !== 32'd1) begin
      errors++; $display("FAIL b2b_flag got fv %b last %b cnt %0d want 1 1 1", frag_valid_o, frag_last_o, frag_cnt_o);
    end
    tick();
    ax_valid_i = 1'b0; #1;
    checks++;
    if (ax_valid_o !== 1'b1 || ax_o !== b) begin
      errors++; $display("FAIL b2b_second got v %b ax %h want v 1 ax %h", ax_valid_o, ax_o, b);
    end
    collect(4);
    checks++;
    if (frag_cnt_o !== 32'd2 || busy_o !== 1'b0) begin
      errors++; $display("FAIL b2b_end got cnt %0d busy %b want 2 0", frag_cnt_o, busy_o);
    end
  endtask

  task automatic test_fixed();
    clr_cnt();
    len_limit_i = 8'd0;
    send(mk(32'h40, 8'd3, 3'd2, BurstFixed));
    collect(8);
    checks++;
    if (n_frag !== 4 || n_flag !== 4) begin
      errors++; $display("FAIL fixed_count frags %0d flags %0d want 4 4", n_frag, n_flag);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (f_len[i] !== 8'd0 || f_addr[i] !== 32'h40 || f_flag[i] !== (i == 3)) begin
          errors++;
          $display("FAIL fixed_frag%0d got len %0d addr %h flag %b want len 0 addr 00000040 flag %b",
                   i, f_len[i], f_addr[i], f_flag[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_flag_backpressure();
    int hs;
    bit done;
    clr_cnt();
    len_limit_i = 8'd0;
    frag_ready_i = 1'b0;
    send(mk(32'h0, 8'd7, 3'd0, BurstIncr));
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      if (ax_valid_o && ax_ready_i) hs++;
      tick();
    end
    checks++;
    if (hs !== 2) begin errors++; $display("FAIL bp_issued got %0d want 2", hs); end
    checks++;
    if (ax_valid_o !== 1'b0 || frag_valid_o !== 1'b1 || frag_last_o !== 1'b0) begin
      errors++; $display("FAIL bp_stall got v %b fv %b last %b want 0 1 0", ax_valid_o, frag_valid_o, frag_last_o);
    end
    frag_ready_i = 1'b1;
    tick();
    frag_ready_i = 1'b0; #1;
    hs = 0;
    for (int c = 0; c < 4; c++) begin
      if (ax_valid_o && ax_ready_i) hs++;
      tick();
    end
    checks++;
    if (hs !== 1) begin errors++; $display("FAIL bp_release got %0d want 1", hs); end
    frag_ready_i = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (!busy_o) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done || frag_cnt_o !== 32'd8) begin
      errors++; $display("FAIL bp_drain got done %b cnt %0d want 1 8", done, frag_cnt_o);
    end
  endtask

  task automatic test_limit_latch();
    len_limit_i = 8'd0;
    send(mk(32'h100, 8'd3, 3'd0, BurstIncr));
    len_limit_i = 8'd3;
    collect(8);
    checks++;
    if (n_frag !== 4) begin
      errors++; $display("FAIL latch_count got %0d want 4", n_frag);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (f_len[i] !== 8'd0 || f_addr[i] !== 32'h100 + i) begin
          errors++; $display("FAIL latch_frag%0d got len %0d addr %h want len 0 addr %h",
                             i, f_len[i], f_addr[i], 32'h100 + i);
        end
      end
    end
    send(mk(32'h100, 8'd3, 3'd0, BurstIncr));
    collect(5);
    checks++;
    if (n_frag !== 1 || f_len[0] !== 8'd3 || f_flag[0] !== 1'b1) begin
      errors++; $display("FAIL latch_next got frags %0d len %0d flag %b want 1 3 1", n_frag, f_len[0], f_flag[0]);
    end
  endtask

  task automatic test_mid_reset();
    int hs;
    clr_cnt();
    len_limit_i = 8'd0;
    frag_ready_i = 1'b0;
    send(mk(32'h500, 8'd3, 3'd0, BurstIncr));
    tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; frag_ready_i = 1'b1; #1;
    checks++;
    if ({ax_valid_o, frag_valid_o, ax_ready_o, busy_o} !== 4'b0010) begin
      errors++; $display("FAIL midrst_flags got %b want 0010", {ax_valid_o, frag_valid_o, ax_ready_o, busy_o});
    end
    checks++;
    if (frag_cnt_o !== 32'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", frag_cnt_o); end
    hs = 0;
    for (int c = 0; c < 4; c++) begin
      if (ax_valid_o) hs++;
      tick();
    end
    checks++;
    if (hs !== 0) begin errors++; $display("FAIL midrst_quiet got %0d fragments want 0", hs); end
  endtask

  initial begin
    test_reset();
    test_incr_split();
    test_back_to_back();
    test_fixed();
    test_flag_backpressure();
    test_limit_latch();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
